// File: rtl/disp_share_arbiter.sv
// Round-robin owner of the shared 4-digit display: three sources request the screen,
// and a granted source stays on screen for at least HOLD_TICKS time-base strobes.
module disp_share_arbiter #(
    parameter int HOLD_TICKS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [2:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    output logic [2:0]  grant,
    output logic        busy,
    output logic [3:0]  dig3,
    output logic [3:0]  dig2,
    output logic [3:0]  dig1,
    output logic [3:0]  dig0
);

    localparam int              CNT_W    = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_TICKS);
    localparam logic [15:0]     BLANK    = 16'hDDDD;

    typedef enum logic [1:0] {IDLE, GRANT, LINGER} state_t;

    state_t           state;
    logic [1:0]       owner;
    logic [1:0]       last;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      digits;

    logic [3:0]  req_x;
    logic [1:0]  base, c1, c2, nxt;
    logic [15:0] owner_data, nxt_data;
    logic        any_req, owner_req, other_req, cnt_zero;
    logic        release_now, start_grant;

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        onehot = 3'b001 << idx;
    endfunction

    // Padded so a 2-bit index can never select outside the vector.
    assign req_x     = {1'b0, req};
    assign any_req   = |req;
    assign owner_req = req_x[owner];
    assign other_req = |(req & ~onehot(owner));
    assign cnt_zero  = (cnt == '0);

    // Scan order (base+1)%3, (base+2)%3, base; base is the owner being released.
    always_comb begin
        base = (state == IDLE) ? last : owner;
        c1   = (base == 2'd2) ? 2'd0 : base + 2'd1;
        c2   = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        if (req_x[c1])      nxt = c1;
        else if (req_x[c2]) nxt = c2;
        else                nxt = base;
    end

    always_comb begin
        case (owner)
            2'd0:    owner_data = data0;
            2'd1:    owner_data = data1;
            default: owner_data = data2;
        endcase
        case (nxt)
            2'd0:    nxt_data = data0;
            2'd1:    nxt_data = data1;
            default: nxt_data = data2;
        endcase
    end

    // Release decisions look at the registered cnt, never the value a same-edge tick produces.
    always_comb begin
        release_now = 1'b0;
        case (state)
            GRANT:   release_now = cnt_zero && (!owner_req || other_req);
            LINGER:  release_now = cnt_zero;
            default: release_now = 1'b0;
        endcase
    end

    assign start_grant = any_req && ((state == IDLE) || release_now);

    // NOTE: all state and outputs update with <= so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= 2'd0;
            last   <= 2'd2;
            cnt    <= '0;
            grant  <= 3'b000;
            busy   <= 1'b0;
            digits <= BLANK;
        end else if (start_grant) begin
            if (state != IDLE) last <= owner;
            owner  <= nxt;
            grant  <= onehot(nxt);
            busy   <= 1'b1;
            digits <= nxt_data;
            cnt    <= HOLD_CNT;
            state  <= GRANT;
        end else if (release_now) begin
            last   <= owner;
            grant  <= 3'b000;
            busy   <= 1'b0;
            digits <= BLANK;
            cnt    <= '0;
            state  <= IDLE;
        end else begin
            if (tick && !cnt_zero) cnt <= cnt - CNT_W'(1);
            if (state == GRANT) begin
                if (!owner_req) state  <= LINGER;
                else            digits <= owner_data;
            end
        end
    end

    assign dig3 = digits[15:12];
    assign dig2 = digits[11:8];
    assign dig1 = digits[7:4];
    assign dig0 = digits[3:0];

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Directed bench for disp_share_arbiter: one instance with HOLD_TICKS=3, one with HOLD_TICKS=0.
module tb_disp_share_arbiter;

    logic        clk = 1'b0;
    logic        rst, tick;
    logic [2:0]  req;
    logic [15:0] data0, data1, data2;
    logic [2:0]  grant;
    logic        busy;
    logic [3:0]  dig3, dig2, dig1, dig0;

    logic        z_rst, z_tick;
    logic [2:0]  z_req;
    logic [15:0] z_data0, z_data1, z_data2;
    logic [2:0]  z_grant;
    logic        z_busy;
    logic [3:0]  z_dig3, z_dig2, z_dig1, z_dig0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    disp_share_arbiter #(.HOLD_TICKS(3)) dut (
        .clk(clk), .rst(rst), .tick(tick), .req(req),
        .data0(data0), .data1(data1), .data2(data2),
        .grant(grant), .busy(busy),
        .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0)
    );

    disp_share_arbiter #(.HOLD_TICKS(0)) dut0 (
        .clk(clk), .rst(z_rst), .tick(z_tick), .req(z_req),
        .data0(z_data0), .data1(z_data1), .data2(z_data2),
        .grant(z_grant), .busy(z_busy),
        .dig3(z_dig3), .dig2(z_dig2), .dig1(z_dig1), .dig0(z_dig0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
    endtask

    task automatic check_main(input string tag, input logic [2:0] g, input logic b, input logic [15:0] d);
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_busy"}, 32'(busy), 32'(b));
        check({tag, "_digits"}, 32'({dig3, dig2, dig1, dig0}), 32'(d));
    endtask

    task automatic check_z(input string tag, input logic [2:0] g, input logic [15:0] d);
        check({tag, "_grant"}, 32'(z_grant), 32'(g));
        check({tag, "_digits"}, 32'({z_dig3, z_dig2, z_dig1, z_dig0}), 32'(d));
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; req = 3'b000;
        data0 = 16'h0000; data1 = 16'h0000; data2 = 16'h0000;
        z_rst = 1'b1; z_tick = 1'b0; z_req = 3'b000;
        z_data0 = 16'h0000; z_data1 = 16'h0000; z_data2 = 16'h0000;

        // 1: reset values, and idle stays idle without requests
        cyc(); cyc();
        check_main("rst", 3'b000, 1'b0, 16'hDDDD);
        check_z("z_rst", 3'b000, 16'hDDDD);
        rst = 1'b0;
        cyc();
        check_main("idle_noreq", 3'b000, 1'b0, 16'hDDDD);

        // 2: single requester, live update, keeps grant past hold time
        data1 = 16'h1234; req = 3'b010;
        cyc();
        check_main("sole_grant", 3'b010, 1'b1, 16'h1234);
        data1 = 16'h5678;
        cyc();
        check_main("live_update", 3'b010, 1'b1, 16'h5678);
        for (int i = 0; i < 10; i++) tick_pulse();
        check_main("sole_keep", 3'b010, 1'b1, 16'h5678);

        // 3: all three request from reset, rotation after HOLD_TICKS ticks
        rst = 1'b1; req = 3'b000;
        cyc();
        check_main("rst2", 3'b000, 1'b0, 16'hDDDD);
        rst = 1'b0;
        data0 = 16'h1111; data1 = 16'h2222; data2 = 16'hCAFE;
        req = 3'b111;
        cyc();
        check_main("rr_first", 3'b001, 1'b1, 16'h1111);
        tick_pulse(); tick_pulse();
        tick = 1'b1; cyc(); tick = 1'b0;
        check_main("rr_hold0", 3'b001, 1'b1, 16'h1111);
        cyc();
        check_main("rr_to1", 3'b010, 1'b1, 16'h2222);
        tick_pulse(); tick_pulse(); tick_pulse();
        check_main("rr_to2", 3'b100, 1'b1, 16'hCAFE);
        tick_pulse(); tick_pulse(); tick_pulse();
        check_main("rr_wrap", 3'b001, 1'b1, 16'h1111);

        // 4: request dropped mid-hold lingers with frozen digits, then goes idle
        rst = 1'b1; req = 3'b000;
        cyc();
        rst = 1'b0; req = 3'b001;
        cyc();
        check_main("lg_grant", 3'b001, 1'b1, 16'h1111);
        tick_pulse();
        req = 3'b000;
        cyc();
        check_main("lg_enter", 3'b001, 1'b1, 16'h1111);
        data0 = 16'h9999;
        tick_pulse();
        check_main("lg_frozen", 3'b001, 1'b1, 16'h1111);
        tick = 1'b1; cyc(); tick = 1'b0;
        check_main("lg_hold0", 3'b001, 1'b1, 16'h1111);
        cyc();
        check_main("lg_idle", 3'b000, 1'b0, 16'hDDDD);

        // 6: reset while granted, request still held regrants after reset
        data2 = 16'h9876; req = 3'b100;
        cyc();
        check_main("rs_grant", 3'b100, 1'b1, 16'h9876);
        rst = 1'b1;
        cyc();
        check_main("rs_reset", 3'b000, 1'b0, 16'hDDDD);
        rst = 1'b0;
        cyc();
        check_main("rs_regrant", 3'b100, 1'b1, 16'h9876);

        // 5: HOLD_TICKS=0 alternates every clock while both requests held
        z_rst = 1'b0; z_data0 = 16'hAAAA; z_data1 = 16'hBBBB; z_req = 3'b011;
        cyc();
        check_z("z_first", 3'b001, 16'hAAAA);
        check("z_busy", 32'(z_busy), 32'(1));
        cyc();
        check_z("z_alt1", 3'b010, 16'hBBBB);
        cyc();
        check_z("z_alt2", 3'b001, 16'hAAAA);
        cyc();
        check_z("z_alt3", 3'b010, 16'hBBBB);
        z_req = 3'b001;
        cyc();
        check_z("z_handback", 3'b001, 16'hAAAA);
        cyc();
        check_z("z_sole", 3'b001, 16'hAAAA);
        z_req = 3'b000;
        cyc();
        check_z("z_idle", 3'b000, 16'hDDDD);
        check("z_idle_busy", 32'(z_busy), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
